nios_cpu_debug_ocimem_ctrl: RTL and testbench

// - Debug-side consumer of the debug slave's sysclk command strobes; owns the on-chip debug memory (OCIMEM).
// - Executes JTAG read/write commands carried on jdo.
// - Returns MonDReg/monitor_ready/monitor_error to the debug slave TCK logic.
// - Shares the RAM with a CPU-side slave port; JTAG has priority.

---
 rtl/nios_cpu_debug_ocimem_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_nios_cpu_debug_ocimem_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_cpu_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios_cpu_debug_ocimem_ctrl
// Brief    : On-chip debug memory owner; runs JTAG read/write commands and
//            shares the RAM with a CPU slave port (JTAG has priority).
//            Optional macro NIOS_OCIMEM_PARITY_EN adds a stored parity bit.
// Revision : 1.0
// ============================================================================
module nios_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic              cpu_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

`ifdef NIOS_OCIMEM_PARITY_EN
    localparam int c_ram_w = 33;
`else
    localparam int c_ram_w = 32;
`endif
    localparam int                c_depth      = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_reset_addr = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] c_addr_max   = '1;

    localparam logic [1:0] c_cmd_none = 2'd0;
    localparam logic [1:0] c_cmd_a    = 2'd1;
    localparam logic [1:0] c_cmd_b    = 2'd2;
    localparam logic [1:0] c_cmd_n    = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_J_RD = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_jaddr;
    logic [31:0]         r_mondreg;
    logic                r_ready;
    logic                r_error;
    logic                r_pend_valid;
    logic [1:0]          r_pend_kind;
    logic [37:0]         r_pend_jdo;
    logic                r_cpu_rvalid;
    logic [c_ram_w-1:0]  r_q;
    logic [c_ram_w-1:0]  r_mem [c_depth];

    logic [1:0]          w_live_kind;
    logic [1:0]          w_cmd_kind;
    logic [37:0]         w_cmd_jdo;
    logic                w_cpu_accept;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [3:0]          w_ram_be;
    logic [31:0]         w_ram_wdata;
    logic                w_unused;

    assign w_live_kind = take_action_ocimem_a    ? c_cmd_a :
                         take_action_ocimem_b    ? c_cmd_b :
                         take_no_action_ocimem_a ? c_cmd_n : c_cmd_none;

    // A strobe captured during J_RD is replayed in the following IDLE cycle
    // and takes precedence over anything arriving live in that cycle.
    always_comb begin
        w_cmd_kind = c_cmd_none;
        w_cmd_jdo  = jdo;
        if (r_state == ST_IDLE) begin
            if (r_pend_valid) begin
                w_cmd_kind = r_pend_kind;
                w_cmd_jdo  = r_pend_jdo;
            end else begin
                w_cmd_kind = w_live_kind;
            end
        end
    end

    assign cpu_waitrequest = (w_live_kind != c_cmd_none) | r_pend_valid |
                             (r_state == ST_J_RD);
    assign w_cpu_accept    = (cpu_read | cpu_write) & ~cpu_waitrequest;

    always_comb begin
        w_ram_addr  = cpu_address;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_be    = 4'b0000;
        w_ram_wdata = cpu_writedata;
        case (w_cmd_kind)
            c_cmd_a: begin
                w_ram_addr = w_cmd_jdo[26 +: ADDR_W];
                w_ram_re   = w_cmd_jdo[35];
            end
            c_cmd_b: begin
                w_ram_addr  = r_jaddr;
                w_ram_we    = 1'b1;
                w_ram_be    = 4'b1111;
                w_ram_wdata = w_cmd_jdo[34:3];
            end
            c_cmd_n: begin
                w_ram_addr = r_jaddr;
                w_ram_re   = 1'b1;
            end
            default: begin
                if (w_cpu_accept) begin
                    w_ram_we = cpu_write;
                    w_ram_be = cpu_byteenable;
                    w_ram_re = cpu_read & ~cpu_write;
                end
            end
        endcase
    end

`ifdef NIOS_OCIMEM_PARITY_EN
    logic [31:0] w_merged;
    logic        r_rd_chk;

    // Parity covers the whole word, so partial writes merge with the old data.
    always_comb begin
        w_merged = r_mem[w_ram_addr][31:0];
        for (int i = 0; i < 4; i++) begin
            if (w_ram_be[i]) w_merged[8*i +: 8] = w_ram_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) r_mem[w_ram_addr] <= {^w_merged, w_merged};
    end
`else
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_ram_be[i]) r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (w_ram_re) begin
            r_q <= r_mem[w_ram_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_jaddr      <= c_reset_addr;
            r_mondreg    <= '0;
            r_ready      <= 1'b0;
            r_error      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_kind  <= c_cmd_none;
            r_pend_jdo   <= '0;
            r_cpu_rvalid <= 1'b0;
`ifdef NIOS_OCIMEM_PARITY_EN
            r_rd_chk     <= 1'b0;
`endif
        end else begin
            r_cpu_rvalid <= w_cpu_accept & cpu_read & ~cpu_write;
            case (r_state)
                ST_IDLE: begin
                    r_pend_valid <= 1'b0;
                    case (w_cmd_kind)
                        c_cmd_a: begin
                            r_ready <= ~w_cmd_jdo[35];
                            r_jaddr <= w_cmd_jdo[26 +: ADDR_W];
                            if (w_cmd_jdo[36]) r_error <= 1'b0;
                            if (w_cmd_jdo[35]) r_state <= ST_J_RD;
                        end
                        c_cmd_b: begin
                            r_ready   <= 1'b1;
                            r_mondreg <= w_cmd_jdo[34:3];
                            r_jaddr   <= r_jaddr + 1'b1;
                            if (r_jaddr == c_addr_max) r_error <= 1'b1;
                        end
                        c_cmd_n: begin
                            r_ready <= 1'b0;
                            r_state <= ST_J_RD;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    r_mondreg <= r_q[31:0];
                    r_jaddr   <= r_jaddr + 1'b1;
                    if (r_jaddr == c_addr_max) r_error <= 1'b1;
                    r_ready   <= 1'b1;
                    r_state   <= ST_IDLE;
                    if (w_live_kind != c_cmd_none) begin
                        r_pend_valid <= 1'b1;
                        r_pend_kind  <= w_live_kind;
                        r_pend_jdo   <= jdo;
                    end
                end
            endcase
`ifdef NIOS_OCIMEM_PARITY_EN
            r_rd_chk <= w_ram_re;
            if (r_rd_chk && (^r_q)) r_error <= 1'b1;
`endif
        end
    end

    assign cpu_readdata      = r_q[31:0];
    assign cpu_readdatavalid = r_cpu_rvalid;
    assign MonDReg           = r_mondreg;
    assign monitor_ready     = r_ready;
    assign monitor_error     = r_error;

    assign w_unused = ^{w_cmd_jdo[37], w_cmd_jdo[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_nios_cpu_debug_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_cpu_debug_ocimem_ctrl
// Brief    : Directed bench for the OCIMEM controller (JTAG + CPU ports).
// Revision : 1.0
// ============================================================================
module tb_nios_cpu_debug_ocimem_ctrl;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;
    logic        cpu_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int checks = 0;
    int errors = 0;

    nios_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .RESET_ADDR(0)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .cpu_waitrequest         (cpu_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic jtag_a(input logic [7:0] addr, input logic rd, input logic clr);
        logic [37:0] v;
        v = '0;
        v[33:26] = addr;
        v[35] = rd;
        v[36] = clr;
        jdo = v;
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] data);
        logic [37:0] v;
        v = '0;
        v[34:3] = data;
        jdo = v;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jtag_n();
        take_no_action_ocimem_a = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        cpu_address = addr;
        cpu_writedata = data;
        cpu_byteenable = be;
        cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (MonDReg !== 32'h0) begin errors++; $display("FAIL rst_mondreg: got %h expected 00000000", MonDReg); end
        checks++;
        if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", monitor_ready); end
        checks++;
        if (monitor_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", monitor_error); end
        checks++;
        if (cpu_readdatavalid !== 1'b0 || cpu_readdata !== 32'h0) begin
            errors++; $display("FAIL rst_cpu: got valid %b data %h expected 0 00000000", cpu_readdatavalid, cpu_readdata);
        end
        checks++;
        if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b expected 0", cpu_waitrequest); end
    endtask

    task automatic test_jtag_write();
        jtag_a(8'h10, 1'b0, 1'b0);
        checks++;
        if (monitor_ready !== 1'b1) begin errors++; $display("FAIL a_noread_ready: got %b expected 1", monitor_ready); end
        idle(3);
        jtag_b(32'hDEADBEEF);
        checks++;
        if (MonDReg !== 32'hDEADBEEF) begin errors++; $display("FAIL b_mondreg: got %h expected deadbeef", MonDReg); end
        checks++;
        if (monitor_ready !== 1'b1) begin errors++; $display("FAIL b_ready: got %b expected 1", monitor_ready); end
        idle(3);
        jtag_b(32'h0BADF00D);
        idle(3);
    endtask

    task automatic test_jtag_read();
        jtag_a(8'h10, 1'b1, 1'b0);
        checks++;
        if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_early: got %b expected 0", monitor_ready); end
        tick();
        checks++;
        if (MonDReg !== 32'hDEADBEEF || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL rd_a: got %h/%b expected deadbeef/1", MonDReg, monitor_ready);
        end
        idle(3);
        jtag_n();
        tick();
        checks++;
        if (MonDReg !== 32'h0BADF00D || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL rd_next: got %h/%b expected 0badf00d/1", MonDReg, monitor_ready);
        end
        idle(3);
    endtask

    task automatic test_wrap();
        jtag_a(8'h00, 1'b0, 1'b0);
        jtag_b(32'h600DCAFE);
        idle(3);
        jtag_a(8'hFF, 1'b0, 1'b0);
        checks++;
        if (monitor_error !== 1'b0) begin errors++; $display("FAIL wrap_pre: got %b expected 0", monitor_error); end
        jtag_b(32'hA5A55A5A);
        checks++;
        if (monitor_error !== 1'b1) begin errors++; $display("FAIL wrap_b_err: got %b expected 1", monitor_error); end
        idle(3);
        jtag_a(8'h80, 1'b0, 1'b1);
        checks++;
        if (monitor_error !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", monitor_error); end
        idle(3);
        jtag_a(8'hFF, 1'b0, 1'b0);
        idle(3);
        jtag_n();
        tick();
        checks++;
        if (MonDReg !== 32'hA5A55A5A || monitor_error !== 1'b1) begin
            errors++; $display("FAIL wrap_n: got %h/%b expected a5a55a5a/1", MonDReg, monitor_error);
        end
        idle(3);
        jtag_n();
        tick();
        checks++;
        if (MonDReg !== 32'h600DCAFE || monitor_error !== 1'b1) begin
            errors++; $display("FAIL wrap_addr0: got %h/%b expected 600dcafe/1", MonDReg, monitor_error);
        end
        idle(3);
        jtag_a(8'h40, 1'b0, 1'b1);
        checks++;
        if (monitor_error !== 1'b0 || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL wrap_clear: got err %b rdy %b expected 0 1", monitor_error, monitor_ready);
        end
        idle(3);
    endtask

    task automatic test_cpu();
        cpu_address = 8'h20;
        cpu_writedata = 32'hAABBCCDD;
        cpu_byteenable = 4'b1111;
        cpu_write = 1'b1;
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL cpu_wr_wait: got %b expected 0", cpu_waitrequest); end
        tick();
        cpu_write = 1'b0;
        cpu_wr(8'h20, 32'h11223344, 4'b0101);
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        tick();
        cpu_read = 1'b0;
        checks++;
        if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'hAA22CC44) begin
            errors++; $display("FAIL cpu_rd: got %b/%h expected 1/aa22cc44", cpu_readdatavalid, cpu_readdata);
        end
        tick();
        checks++;
        if (cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_pulse: got %b expected 0", cpu_readdatavalid); end
        cpu_address = 8'h21;
        cpu_writedata = 32'h00000055;
        cpu_byteenable = 4'b1111;
        cpu_read = 1'b1;
        cpu_write = 1'b1;
        tick();
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        checks++;
        if (cpu_readdatavalid !== 1'b0) begin errors++; $display("FAIL cpu_rw_valid: got %b expected 0", cpu_readdatavalid); end
        cpu_read = 1'b1;
        tick();
        cpu_read = 1'b0;
        checks++;
        if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'h00000055) begin
            errors++; $display("FAIL cpu_rw_data: got %b/%h expected 1/00000055", cpu_readdatavalid, cpu_readdata);
        end
        idle(2);
    endtask

    task automatic test_collision();
        jtag_a(8'h30, 1'b0, 1'b0);
        jtag_b(32'h13572468);
        idle(3);
        jtag_a(8'h30, 1'b0, 1'b0);
        idle(3);
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        take_no_action_ocimem_a = 1'b1;
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL col_wait0: got %b expected 1", cpu_waitrequest); end
        tick();
        take_no_action_ocimem_a = 1'b0;
        #1;
        checks++;
        if (cpu_waitrequest !== 1'b1 || cpu_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL col_wait1: got wait %b valid %b expected 1 0", cpu_waitrequest, cpu_readdatavalid);
        end
        tick();
        checks++;
        if (cpu_waitrequest !== 1'b0) begin errors++; $display("FAIL col_wait2: got %b expected 0", cpu_waitrequest); end
        checks++;
        if (MonDReg !== 32'h13572468 || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL col_jtag: got %h/%b expected 13572468/1", MonDReg, monitor_ready);
        end
        tick();
        cpu_read = 1'b0;
        checks++;
        if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== 32'hAA22CC44) begin
            errors++; $display("FAIL col_cpu: got %b/%h expected 1/aa22cc44", cpu_readdatavalid, cpu_readdata);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        jtag_a(8'h30, 1'b1, 1'b0);
        jtag_b(32'h0F0F0F0F);
        checks++;
        if (MonDReg !== 32'h13572468 || monitor_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_rd: got %h/%b expected 13572468/1", MonDReg, monitor_ready);
        end
        checks++;
        if (cpu_waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_wait: got %b expected 1", cpu_waitrequest); end
        tick();
        checks++;
        if (MonDReg !== 32'h0F0F0F0F) begin errors++; $display("FAIL b2b_pend: got %h expected 0f0f0f0f", MonDReg); end
        idle(3);
        jtag_a(8'h31, 1'b1, 1'b0);
        tick();
        checks++;
        if (MonDReg !== 32'h0F0F0F0F) begin errors++; $display("FAIL b2b_ram: got %h expected 0f0f0f0f", MonDReg); end
        idle(3);
    endtask

    task automatic test_reset_mid_read();
        jtag_a(8'h10, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (MonDReg !== 32'h0 || monitor_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_now: got %h/%b expected 00000000/0", MonDReg, monitor_ready);
        end
        tick();
        reset_n = 1'b1;
        idle(2);
        checks++;
        if (MonDReg !== 32'h0 || monitor_ready !== 1'b0 || cpu_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: got %h/%b/%b expected 00000000/0/0", MonDReg, monitor_ready, cpu_readdatavalid);
        end
        idle(2);
    endtask

`ifdef NIOS_OCIMEM_PARITY_EN
    task automatic test_parity();
        jtag_a(8'h05, 1'b0, 1'b0);
        jtag_b(32'h00000003);
        idle(3);
        dut.r_mem[5] = dut.r_mem[5] ^ 33'h1;
        jtag_a(8'h05, 1'b1, 1'b0);
        tick();
        checks++;
        if (monitor_error !== 1'b1 || MonDReg !== 32'h00000002) begin
            errors++; $display("FAIL parity: got err %b data %h expected 1 00000002", monitor_error, MonDReg);
        end
        idle(3);
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        cpu_byteenable = '0;
        idle(3);
        test_reset();
        reset_n = 1'b1;
        idle(2);
        test_jtag_write();
        test_jtag_read();
        test_wrap();
        test_cpu();
        test_collision();
        test_back_to_back();
        test_reset_mid_read();
`ifdef NIOS_OCIMEM_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
